// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT: sequencer FSM states, width helpers
// and the twiddle ROM word layout used by the butterfly.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  // Twiddle ROM word: {im, re}, both signed fixed point.
  typedef struct packed {
    logic signed [31:0] im;
    logic signed [31:0] re;
  } tw_word_t;

  localparam int TW_W = $bits(tw_word_t);

  function automatic int calc_log2n(input int n);
    return $clog2(n);
  endfunction

  function automatic int calc_addr_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int calc_stg_w(input int n);
    return $clog2($clog2(n));
  endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// In-place radix-2 DIT FFT address sequencer: walks LOG2N stages of N/2 butterflies,
// issuing data RAM a/b addresses and twiddle ROM addresses, with a drain gap per stage.
module fft_bfly_addr_gen
  import fft_pkg::*;
#(
  parameter int N          = 4096,
  parameter int PIPE_DEPTH = 8,
  localparam int LOG2N     = calc_log2n(N),
  localparam int ADDR_W    = calc_addr_w(N),
  localparam int STG_W     = calc_stg_w(N),
  localparam int K_W       = LOG2N - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bf_ready,
  output logic              bf_valid,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] tw_addr,
  output logic [STG_W-1:0]  stage,
  output logic              last_in_stage,
  output logic              busy,
  output logic              done
);

  localparam int DRN_W = $clog2(PIPE_DEPTH) + 1;

  localparam logic [K_W-1:0]   K_LAST   = '1;
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG2N - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_DEPTH - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] tw;
  } bfly_t;

  fsm_e             state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             run_d;
  bfly_t            nxt;

  // pos = low s bits of k; group index is shifted up one bit to leave room for the span bit.
  function automatic bfly_t bfly_addr(input logic [K_W-1:0] k, input logic [STG_W-1:0] s);
    logic [ADDR_W-1:0] kx, pos, a;
    bfly_t r;
    kx   = {1'b0, k};
    pos  = kx & ((ADDR_W'(1) << s) - ADDR_W'(1));
    a    = (((kx >> s) << s) << 1) | pos;
    r.a  = a;
    r.b  = a | (ADDR_W'(1) << s);
    r.tw = pos << (STG_LAST - s);
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          stage_d = '0;
        end
      end
      RUN: begin
        if (bf_ready) begin
          k_d = k_q + 1'b1;
          if (k_q == K_LAST) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRN_LAST) begin
          drain_d = '0;
          if (stage_q == STG_LAST) begin
            state_d = DONE;
          end else begin
            stage_d = stage_q + 1'b1;
            state_d = RUN;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign run_d = (state_d == RUN);
  assign nxt   = bfly_addr(k_d, stage_d);

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      k_q           <= '0;
      stage_q       <= '0;
      drain_q       <= '0;
      bf_valid      <= 1'b0;
      addr_a        <= '0;
      addr_b        <= '0;
      tw_addr       <= '0;
      stage         <= '0;
      last_in_stage <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      stage_q       <= stage_d;
      drain_q       <= drain_d;
      bf_valid      <= run_d;
      addr_a        <= run_d ? nxt.a : '0;
      addr_b        <= run_d ? nxt.b : '0;
      tw_addr       <= run_d ? nxt.tw : '0;
      stage         <= run_d ? stage_d : '0;
      last_in_stage <= run_d && (k_d == K_LAST);
      busy          <= (state_d == RUN) || (state_d == DRAIN);
      done          <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_fft_bfly_addr_gen.sv
// Bench for fft_bfly_addr_gen: three instances (N=8, 64, 4096) checked against a
// butterfly-order reference list built from stage/group/position loops.
module tb_fft_bfly_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       st8, rdy8, v8, last8, busy8, done8;
  logic [2:0] a8, b8, tw8;
  logic [1:0] stg8;

  logic       st64, rdy64, v64, last64, busy64, done64;
  logic [5:0] a64, b64, tw64;
  logic [2:0] stg64;

  logic        stB, rdyB, vB, lastB, busyB, doneB;
  logic [11:0] aB, bB, twB;
  logic [3:0]  stgB;

  fft_bfly_addr_gen #(.N(8), .PIPE_DEPTH(4)) u_d8 (
    .clk(clk), .rst(rst), .start(st8), .bf_ready(rdy8), .bf_valid(v8),
    .addr_a(a8), .addr_b(b8), .tw_addr(tw8), .stage(stg8),
    .last_in_stage(last8), .busy(busy8), .done(done8));

  fft_bfly_addr_gen #(.N(64), .PIPE_DEPTH(3)) u_d64 (
    .clk(clk), .rst(rst), .start(st64), .bf_ready(rdy64), .bf_valid(v64),
    .addr_a(a64), .addr_b(b64), .tw_addr(tw64), .stage(stg64),
    .last_in_stage(last64), .busy(busy64), .done(done64));

  fft_bfly_addr_gen #(.N(4096), .PIPE_DEPTH(8)) u_big (
    .clk(clk), .rst(rst), .start(stB), .bf_ready(rdyB), .bf_valid(vB),
    .addr_a(aB), .addr_b(bB), .tw_addr(twB), .stage(stgB),
    .last_in_stage(lastB), .busy(busyB), .done(doneB));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int a;
    int b;
    int tw;
    int s;
    bit last;
  } bf_t;

  bf_t exp_q[$];

  // Reference order: per stage, groups of 2*span words, span butterflies per group.
  function automatic void build_ref(input int n);
    int lg, span, ng;
    bf_t t;
    lg = $clog2(n);
    exp_q.delete();
    for (int s = 0; s < lg; s++) begin
      span = 1 << s;
      ng   = n / (2 * span);
      for (int g = 0; g < ng; g++) begin
        for (int p = 0; p < span; p++) begin
          t.a    = g * 2 * span + p;
          t.b    = t.a + span;
          t.tw   = p * (n / (2 * span));
          t.s    = s;
          t.last = (g == ng - 1) && (p == span - 1);
          exp_q.push_back(t);
        end
      end
    end
  endfunction

  task automatic run8(input bit rnd, input bit spurious, input int rst_cyc);
    int   gap_left, stages_done;
    bit   prev_stall, finished;
    logic [2:0] pa, pb, ptw;
    logic [1:0] ps;
    logic pl;
    bf_t  t;
    build_ref(8);
    gap_left = 0; stages_done = 0; prev_stall = 0; finished = 0;
    pa = '0; pb = '0; ptw = '0; ps = '0; pl = 1'b0;
    @(negedge clk);
    chk("d8_idle_valid", v8, 0);
    chk("d8_idle_busy", busy8, 0);
    st8  = 1'b1;
    rdy8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 1; c <= 300 && !finished; c++) begin
      @(negedge clk);
      st8 = spurious && (c == 3 || c == 10);
      if (rst_cyc >= 0 && c == rst_cyc + 1) begin
        chk("d8_rst_valid", v8, 0);
        chk("d8_rst_busy", busy8, 0);
        chk("d8_rst_done", done8, 0);
        chk("d8_rst_a", a8, 0);
        chk("d8_rst_b", b8, 0);
        chk("d8_rst_tw", tw8, 0);
        chk("d8_rst_stage", stg8, 0);
        chk("d8_rst_last", last8, 0);
        rst = 1'b0;
        finished = 1;
      end else begin
        if (c == 1) chk("d8_first_valid", v8, 1);
        if (prev_stall) begin
          chk("d8_stall_valid", v8, 1);
          chk("d8_stall_a", a8, pa);
          chk("d8_stall_b", b8, pb);
          chk("d8_stall_tw", tw8, ptw);
          chk("d8_stall_stage", stg8, ps);
          chk("d8_stall_last", last8, pl);
        end
        if (gap_left > 0) begin
          chk("d8_gap_valid", v8, 0);
          chk("d8_gap_busy", busy8, 1);
          chk("d8_gap_done", done8, 0);
          gap_left--;
        end else if (stages_done == 3) begin
          chk("d8_done", done8, 1);
          chk("d8_done_busy", busy8, 0);
          chk("d8_done_valid", v8, 0);
          if (!rnd) chk("d8_done_cycle", c, 25);
          finished = 1;
        end else begin
          chk("d8_run_valid", v8, 1);
          chk("d8_run_busy", busy8, 1);
          chk("d8_run_done", done8, 0);
        end
        rdy8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_stall = v8 && !rdy8;
        pa = a8; pb = b8; ptw = tw8; ps = stg8; pl = last8;
        if (v8 && rdy8) begin
          if (exp_q.size() == 0) begin
            chk("d8_extra_accept", 1, 0);
          end else begin
            t = exp_q.pop_front();
            chk("d8_a", a8, t.a);
            chk("d8_b", b8, t.b);
            chk("d8_tw", tw8, t.tw);
            chk("d8_stage", stg8, t.s);
            chk("d8_last", last8, t.last);
            if (t.last) begin
              gap_left = 4;
              stages_done++;
            end
          end
        end
        if (c == rst_cyc) rst = 1'b1;
      end
    end
    if (!finished) chk("d8_timeout", 0, 1);
    st8 = 1'b0;
    rdy8 = 1'b0;
    if (rst_cyc < 0) chk("d8_left", exp_q.size(), 0);
    repeat (3) begin
      @(negedge clk);
      chk("d8_after_done", done8, 0);
      chk("d8_after_busy", busy8, 0);
      chk("d8_after_valid", v8, 0);
    end
  endtask

  task automatic run64();
    int  cnt[64];
    int  acc, acc_stage;
    bit  prev_stall, fin;
    logic [5:0] pa, pb, ptw;
    bf_t t;
    build_ref(64);
    acc = 0; acc_stage = 0; prev_stall = 0; fin = 0;
    pa = '0; pb = '0; ptw = '0;
    foreach (cnt[i]) cnt[i] = 0;
    @(negedge clk);
    st64  = 1'b1;
    rdy64 = 1'b0;
    for (int c = 1; c <= 2000 && !fin; c++) begin
      @(negedge clk);
      st64 = 1'b0;
      if (prev_stall) begin
        chk("d64_stall_a", a64, pa);
        chk("d64_stall_b", b64, pb);
        chk("d64_stall_tw", tw64, ptw);
      end
      if (done64) fin = 1;
      rdy64 = 1'($urandom_range(0, 1));
      prev_stall = v64 && !rdy64;
      pa = a64; pb = b64; ptw = tw64;
      if (v64 && rdy64) begin
        acc++;
        if (exp_q.size() == 0) begin
          chk("d64_extra_accept", 1, 0);
        end else begin
          t = exp_q.pop_front();
          chk("d64_a", a64, t.a);
          chk("d64_b", b64, t.b);
          chk("d64_tw", tw64, t.tw);
          chk("d64_stage", stg64, t.s);
        end
        chk("d64_last", last64, acc_stage == 31);
        cnt[a64]++;
        cnt[b64]++;
        acc_stage++;
        if (acc_stage == 32) begin
          for (int i = 0; i < 64; i++) begin
            chk("d64_touch", cnt[i], 1);
            cnt[i] = 0;
          end
          acc_stage = 0;
        end
      end
    end
    if (!fin) chk("d64_timeout", 0, 1);
    chk("d64_accepts", acc, 192);
    rdy64 = 1'b0;
  endtask

  task automatic run_big();
    int acc, k;
    bit fin;
    acc = 0; fin = 0;
    @(negedge clk);
    stB  = 1'b1;
    rdyB = 1'b1;
    for (int c = 1; c <= 30000 && !fin; c++) begin
      @(negedge clk);
      stB = 1'b0;
      if (vB) begin
        if (acc >= 11 * 2048) begin
          k = acc - 11 * 2048;
          chk("big_tw", twB, k);
          chk("big_a", aB, k);
          chk("big_b", bB, k + 2048);
        end
        acc++;
      end
      if (doneB) begin
        chk("big_done_cycle", c, 12 * (2048 + 8) + 1);
        fin = 1;
      end
    end
    if (!fin) chk("big_timeout", 0, 1);
    chk("big_accepts", acc, 24576);
    rdyB = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    st8 = 1'b0;  rdy8 = 1'b0;
    st64 = 1'b0; rdy64 = 1'b0;
    stB = 1'b0;  rdyB = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", v8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_a", a8, 0);
    chk("rst_b", b8, 0);
    chk("rst_tw", tw8, 0);
    chk("rst_stage", stg8, 0);
    chk("rst_last", last8, 0);
    chk("rst64_b", b64, 0);
    chk("rstB_busy", busyB, 0);

    run8(1'b0, 1'b0, -1);
    run8(1'b1, 1'b0, -1);
    run8(1'b1, 1'b0, -1);
    run8(1'b0, 1'b1, -1);
    run8(1'b0, 1'b0, 10);
    run8(1'b0, 1'b0, -1);
    run64();
    run64();
    run_big();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
